// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive engine: state encodings, flag bit
// positions, the default oversampling ratio and the character-width clamp.
package uart_rx_engine_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RXE_IDLE     = 3'd0,
    RXE_START    = 3'd1,
    RXE_DATA     = 3'd2,
    RXE_PARITY   = 3'd3,
    RXE_STOP     = 3'd4,
    RXE_BRK_WAIT = 3'd5
  } rxe_state_e;

  localparam int FLAG_PARITY  = 0;
  localparam int FLAG_FRAMING = 1;
  localparam int FLAG_BREAK   = 2;

  // Out-of-range widths snap to the nearest supported width.
  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
    if (req < 4'd5) return 4'd5;
    if (req > max_bits) return max_bits;
    return req;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, per-bit oversample tick counter and 3-sample majority vote.
// bit_strobe marks the decision tick; bit_val is valid in that same cycle.
module uart_rx_sampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic enable,
  input  logic srx_pad_i,
  input  logic clear,
  output logic rx_s,
  output logic bit_val,
  output logic bit_strobe
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LO   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_HI   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tc;
  logic                   s_lo;
  logic                   s_mid;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], srx_pad_i};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // tc is held at 0 while the engine is not inside a frame.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tc    <= '0;
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else if (clear) begin
      tc <= '0;
    end else if (enable) begin
      tc <= (tc == T_LAST) ? '0 : tc + 1'b1;
      if (tc == T_LO)  s_lo  <= rx_s;
      if (tc == T_MID) s_mid <= rx_s;
    end
  end

  assign bit_strobe = enable && !clear && (tc == T_HI);
  assign bit_val    = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);

endmodule

// File: rtl/uart_rx_engine.sv
// Parametrised UART receive engine: frame FSM, parity/framing/break detection
// and a single-entry valid/ready output register with overrun reporting.
module uart_rx_engine
  import uart_rx_engine_pkg::*;
#(
  parameter int OVERSAMPLE    = DEFAULT_OVERSAMPLE,
  parameter int MAX_DATA_BITS = 9,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     wb_rst_i,
  input  logic                     enable,
  input  logic                     srx_pad_i,
  input  logic                     rx_reset,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_even,
  input  logic                     cfg_parity_stick,
  input  logic                     cfg_stop2,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [MAX_DATA_BITS-1:0] m_data,
  output logic                     m_parity_err,
  output logic                     m_framing_err,
  output logic                     m_break,
  output logic                     overrun,
  output logic [2:0]               rstate
);
  localparam int IW = $clog2(MAX_DATA_BITS);

  rxe_state_e               state;
  logic                     rx_s, bit_val, bit_strobe, sampler_clear;
  logic [3:0]               nbits_q, bit_idx;
  logic                     par_en_q, par_even_q, par_stick_q, stop2_q;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic                     par_bit_q, par_err_q, stop_idx, stop1_q;
  logic                     done;
  logic [MAX_DATA_BITS-1:0] done_data;
  logic [2:0]               done_flags, flags_q;
  logic                     par_err_now, stop1_now, frm_err_now, brk_now;

  assign sampler_clear = rx_reset || (state == RXE_IDLE) || (state == RXE_BRK_WAIT);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .enable    (enable),
    .srx_pad_i (srx_pad_i),
    .clear     (sampler_clear),
    .rx_s      (rx_s),
    .bit_val   (bit_val),
    .bit_strobe(bit_strobe)
  );

  // Stick mode: cfg_parity_even=1 expects a 0 parity bit, 0 expects a 1.
  assign par_err_now = par_stick_q ? (bit_val == par_even_q)
                     : par_even_q  ? (^shreg ^ bit_val)
                     :               !(^shreg ^ bit_val);
  assign stop1_now   = stop_idx ? stop1_q : bit_val;
  assign frm_err_now = !stop1_now || (stop_idx && !bit_val);
  assign brk_now     = (shreg == '0) && !(par_en_q && par_bit_q) && !stop1_now;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= RXE_IDLE;
      nbits_q     <= 4'd8;
      bit_idx     <= '0;
      par_en_q    <= 1'b0;
      par_even_q  <= 1'b0;
      par_stick_q <= 1'b0;
      stop2_q     <= 1'b0;
      shreg       <= '0;
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
      stop_idx    <= 1'b0;
      stop1_q     <= 1'b1;
      done        <= 1'b0;
      done_data   <= '0;
      done_flags  <= '0;
    end else begin
      done <= 1'b0;
      if (rx_reset) begin
        state <= RXE_IDLE;
      end else if (enable) begin
        case (state)
          RXE_IDLE: if (!rx_s) begin
            state       <= RXE_START;
            nbits_q     <= clamp_bits(cfg_data_bits, 4'(MAX_DATA_BITS));
            par_en_q    <= cfg_parity_en;
            par_even_q  <= cfg_parity_even;
            par_stick_q <= cfg_parity_stick;
            stop2_q     <= cfg_stop2;
            shreg       <= '0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            stop_idx    <= 1'b0;
          end
          RXE_START: if (bit_strobe) begin
            state   <= bit_val ? RXE_IDLE : RXE_DATA;
            bit_idx <= '0;
          end
          RXE_DATA: if (bit_strobe) begin
            shreg[bit_idx[IW-1:0]] <= bit_val;
            if (bit_idx == nbits_q - 4'd1) state <= par_en_q ? RXE_PARITY : RXE_STOP;
            else                           bit_idx <= bit_idx + 4'd1;
          end
          RXE_PARITY: if (bit_strobe) begin
            par_bit_q <= bit_val;
            par_err_q <= par_err_now;
            state     <= RXE_STOP;
          end
          RXE_STOP: if (bit_strobe) begin
            if (stop2_q && !stop_idx) begin
              stop1_q  <= bit_val;
              stop_idx <= 1'b1;
            end else begin
              done                     <= 1'b1;
              done_data                <= brk_now ? '0 : shreg;
              done_flags[FLAG_BREAK]   <= brk_now;
              done_flags[FLAG_FRAMING] <= frm_err_now || brk_now;
              done_flags[FLAG_PARITY]  <= par_err_q && !brk_now;
              state                    <= brk_now ? RXE_BRK_WAIT : RXE_IDLE;
            end
          end
          RXE_BRK_WAIT: if (rx_s) state <= RXE_IDLE;
          default: state <= RXE_IDLE;
        endcase
      end
    end
  end

  // Handshake: m_valid/m_data/flags hold until a cycle with m_valid && m_ready;
  // a completion arriving while a character is held and not being taken is dropped.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      flags_q <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_reset) begin
        m_valid <= 1'b0;
      end else if (done) begin
        if (!m_valid || m_ready) begin
          m_valid <= 1'b1;
          m_data  <= done_data;
          flags_q <= done_flags;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign m_parity_err  = flags_q[FLAG_PARITY];
  assign m_framing_err = flags_q[FLAG_FRAMING];
  assign m_break       = flags_q[FLAG_BREAK];
  assign rstate        = state;

endmodule
